// File: rtl/ifetch_cache_pkg.sv
// Shared constants and elaboration helpers for the instruction fetch cache.
package ifetch_cache_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Default bus widths and cache geometry.
  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int DEF_SETS = 128;
  localparam int DEF_WAYS = 2;

  // Width of a per-set replacement pointer. A direct-mapped cache still
  // carries a 1-bit pointer, which simply never leaves zero.
  function automatic int rr_width(input int ways);
    if (ways > 1) begin
      return $clog2(ways);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ifetch_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache's view; master is the surrounding pipeline
// plus memory controller.
interface ifetch_cache_if
  import ifetch_cache_pkg::*;
#(
  parameter int AW = ADDR_LEN,
  parameter int IW = INST_LEN
);
  logic          flush_i;
  logic          inv_all_i;
  logic [AW-1:0] pc_i;
  logic [IW-1:0] inst_o;
  logic [AW-1:0] pc_o;
  logic          inst_valid_o;
  logic          stall_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_done_i;
  logic [IW-1:0] mem_data_i;

  modport slave (
    input  flush_i, inv_all_i, pc_i, mem_done_i, mem_data_i,
    output inst_o, pc_o, inst_valid_o, stall_o, mem_req_o, mem_addr_o
  );

  modport master (
    output flush_i, inv_all_i, pc_i, mem_done_i, mem_data_i,
    input  inst_o, pc_o, inst_valid_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/ifetch_cache_way.sv
// One way of the instruction cache: tag, valid and data arrays with a
// combinational lookup port and a synchronous fill port. Only the valid bits
// are reset; tag/data contents are meaningless until their valid bit is set.
module icache_way #(
  parameter  int SETS = 128,
  parameter  int TAGW = 23,
  parameter  int IW   = 32,
  localparam int IDX  = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDX-1:0]  i_rd_idx,
  input  logic [TAGW-1:0] i_rd_tag,
  output logic            o_hit,
  output logic [IW-1:0]   o_data,
  input  logic            i_we,
  input  logic [IDX-1:0]  i_wr_idx,
  input  logic [TAGW-1:0] i_wr_tag,
  input  logic [IW-1:0]   i_wr_data,
  input  logic            i_inv_all
);

  logic [TAGW-1:0] r_tag  [SETS];
  logic [IW-1:0]   r_data [SETS];
  logic [SETS-1:0] r_valid;

  // Valid bits: invalidate-all wins over a same-cycle fill of this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_inv_all) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Tag/data storage is written on every fill, even one that an
  // invalidate-all leaves invalid; it is never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_data = r_data[i_rd_idx];

endmodule

// File: rtl/ifetch_cache.sv
// N-way set-associative instruction fetch cache. Lookup is combinational over
// all ways of the indexed set; a miss starts a registered, level-held fill
// request to the memory controller. A mispredict flush during a fill drains
// the outstanding response and throws it away, since the controller cannot
// abort. Replacement is round-robin per set.
module ifetch_cache
  import ifetch_cache_pkg::*;
#(
  parameter int AW   = ADDR_LEN,
  parameter int IW   = INST_LEN,
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy,
  ifetch_cache_if.slave  bus
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = AW - 2 - IDX;
  localparam int RRW  = rr_width(WAYS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                r_state;
  logic                      r_mem_req;
  logic [AW-1:0]             r_mem_addr;
  logic [SETS-1:0][RRW-1:0]  r_rr;

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [IDX-1:0]  w_fill_idx;
  logic [TAGW-1:0] w_fill_tag;
  logic [WAYS-1:0] w_way_hit;
  logic [IW-1:0]   w_way_data [WAYS];
  logic [WAYS-1:0] w_way_we;
  logic            w_hit;
  logic [IW-1:0]   w_hit_data;
  logic            w_fill_we;
  logic            w_inv;
  logic            w_active;
  logic            w_fwd;
  logic [RRW-1:0]  w_rr_cur;
  logic [RRW-1:0]  w_rr_next;
  logic            w_inst_valid;
  logic            w_stall;
  logic [IW-1:0]   w_inst;
  logic [AW-1:0]   w_pc;

  // Lookup uses the live PC; fills use the address captured at miss time,
  // so a PC change during the fill cannot corrupt the line being written.
  assign w_idx      = bus.pc_i[IDX+1:2];
  assign w_tag      = bus.pc_i[AW-1:IDX+2];
  assign w_fill_idx = r_mem_addr[IDX+1:2];
  assign w_fill_tag = r_mem_addr[AW-1:IDX+2];

  // A frozen pipeline (rdy low) ignores the memory response and invalidates.
  assign w_fill_we = rdy && (r_state == ST_FILL) && bus.mem_done_i;
  assign w_inv     = rdy && bus.inv_all_i;
  assign w_active  = rst_n && rdy && !bus.flush_i;
  assign w_fwd     = (r_state == ST_FILL) && bus.mem_done_i && (bus.pc_i == r_mem_addr);

  assign w_rr_cur  = r_rr[w_fill_idx];
  assign w_rr_next = (w_rr_cur == RRW'(WAYS - 1)) ? RRW'(0) : (w_rr_cur + RRW'(1));

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_way_we[g] = w_fill_we && (w_rr_cur == RRW'(g));

    icache_way #(
      .SETS (SETS),
      .TAGW (TAGW),
      .IW   (IW)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_idx  (w_idx),
      .i_rd_tag  (w_tag),
      .o_hit     (w_way_hit[g]),
      .o_data    (w_way_data[g]),
      .i_we      (w_way_we[g]),
      .i_wr_idx  (w_fill_idx),
      .i_wr_tag  (w_fill_tag),
      .i_wr_data (bus.mem_data_i),
      .i_inv_all (w_inv)
    );
  end

  // Merge the per-way lookups; at most one way can hit, so an OR is a mux.
  always_comb begin
    w_hit      = FALSE;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit      = w_hit | w_way_hit[w];
      w_hit_data = w_hit_data | ({IW{w_way_hit[w]}} & w_way_data[w]);
    end
  end

  // Fetch-side outputs: hit, same-cycle fill forward, or stall; all zero
  // under reset, flush or a frozen pipeline.
  always_comb begin
    w_inst_valid = FALSE;
    w_stall      = FALSE;
    w_inst       = '0;
    w_pc         = '0;
    if (w_active) begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            w_inst_valid = TRUE;
            w_inst       = w_hit_data;
            w_pc         = bus.pc_i;
          end else begin
            w_stall = TRUE;
          end
        end
        ST_FILL: begin
          if (w_fwd) begin
            w_inst_valid = TRUE;
            w_inst       = bus.mem_data_i;
            w_pc         = bus.pc_i;
          end else begin
            w_stall = TRUE;
          end
        end
        ST_DRAIN: begin
          w_stall = TRUE;
        end
        default: begin
          w_stall = FALSE;
        end
      endcase
    end else begin
      w_stall = FALSE;
    end
  end

  // Miss FSM and the level-held fill request to the memory controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else if (rdy) begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.flush_i && !w_hit) begin
            r_state    <= ST_FILL;
            r_mem_req  <= 1'b1;
            r_mem_addr <= bus.pc_i;
          end
        end
        ST_FILL: begin
          if (bus.mem_done_i) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end else if (bus.flush_i) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.mem_done_i) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Round-robin victim pointer of the filled set advances on each fill write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_fill_we) begin
      r_rr[w_fill_idx] <= w_rr_next;
    end else begin
      r_rr <= r_rr;
    end
  end

  assign bus.inst_o       = w_inst;
  assign bus.pc_o         = w_pc;
  assign bus.inst_valid_o = w_inst_valid;
  assign bus.stall_o      = w_stall;
  assign bus.mem_req_o    = r_mem_req;
  assign bus.mem_addr_o   = r_mem_addr;

endmodule

// File: tb/tb_ifetch_cache.sv
// Directed bench for ifetch_cache (SETS=128, WAYS=2) with a behavioural
// line-level cache model checked every falling edge, plus literal checks.
module tb_ifetch_cache;

  localparam int SETS = 128;
  localparam int WAYS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  int n_checks = 0;
  int n_err    = 0;

  ifetch_cache_if #(.AW(32), .IW(32)) bus ();

  ifetch_cache #(.AW(32), .IW(32), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cache contents as lines per set; mode: 0 = no fill outstanding,
  // 1 = fill outstanding and wanted, 2 = fill outstanding but unwanted.
  bit          m_valid [SETS][WAYS];
  logic [22:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  int          m_rr    [SETS];
  int          m_mode = 0;
  bit          m_req  = 1'b0;
  logic [31:0] m_addr = 32'h0;

  always @(negedge clk) begin
    bit          hit;
    logic [31:0] hdata;
    int          set, ws, fs;
    logic [22:0] tg;
    logic        ev, es;
    logic [31:0] ei, ep;

    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
      m_mode = 0;
      m_req  = 1'b0;
      m_addr = 32'h0;
    end

    set   = int'(bus.pc_i[8:2]);
    tg    = bus.pc_i[31:9];
    hit   = 1'b0;
    hdata = 32'h0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[set][w] && m_tag[set][w] == tg) begin
        hit   = 1'b1;
        hdata = m_data[set][w];
      end
    end

    ev = 1'b0; es = 1'b0; ei = 32'h0; ep = 32'h0;
    if (rst_n && rdy && !bus.flush_i) begin
      if (m_mode == 0) begin
        if (hit) begin ev = 1'b1; ei = hdata; ep = bus.pc_i; end
        else es = 1'b1;
      end else if (m_mode == 1 && bus.mem_done_i && bus.pc_i == m_addr) begin
        ev = 1'b1; ei = bus.mem_data_i; ep = bus.pc_i;
      end else begin
        es = 1'b1;
      end
    end

    check("model_inst_valid", {31'h0, bus.inst_valid_o}, {31'h0, ev});
    check("model_stall", {31'h0, bus.stall_o}, {31'h0, es});
    check("model_inst", bus.inst_o, ei);
    check("model_pc", bus.pc_o, ep);
    check("model_mem_req", {31'h0, bus.mem_req_o}, {31'h0, m_req});
    check("model_mem_addr", bus.mem_addr_o, m_addr);

    if (rst_n && rdy) begin
      if (m_mode == 0) begin
        if (!bus.flush_i && !hit) begin
          m_mode = 1; m_req = 1'b1; m_addr = bus.pc_i;
        end
      end else if (bus.mem_done_i) begin
        if (m_mode == 1) begin
          fs = int'(m_addr[8:2]);
          ws = m_rr[fs];
          m_valid[fs][ws] = 1'b1;
          m_tag[fs][ws]   = m_addr[31:9];
          m_data[fs][ws]  = bus.mem_data_i;
          m_rr[fs]        = (ws + 1) % WAYS;
        end
        m_mode = 0; m_req = 1'b0;
      end else if (m_mode == 1 && bus.flush_i) begin
        m_mode = 2;
      end
      if (bus.inv_all_i) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int k = 0;
    while (bus.mem_req_o !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    check("wait_req_up", {31'h0, bus.mem_req_o}, 32'h1);
    check("wait_req_addr", bus.mem_addr_o, addr);
  endtask

  task automatic fill(input logic [31:0] addr, input logic [31:0] data);
    bus.pc_i = addr;
    cyc();
    wait_req(addr);
    bus.mem_done_i = 1'b1;
    bus.mem_data_i = data;
    #1;
    check("fill_fwd_valid", {31'h0, bus.inst_valid_o}, 32'h1);
    check("fill_fwd_inst", bus.inst_o, data);
    cyc();
    bus.mem_done_i = 1'b0;
    bus.mem_data_i = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; rdy = 1'b1;
    bus.flush_i = 1'b0; bus.inv_all_i = 1'b0; bus.pc_i = 32'h0;
    bus.mem_done_i = 1'b0; bus.mem_data_i = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) cyc();
    bus.pc_i = 32'h0000_0100;
    #1;
    check("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_stall", {31'h0, bus.stall_o}, 32'h0);
    check("rst_valid", {31'h0, bus.inst_valid_o}, 32'h0);
    cyc();
    rst_n = 1'b1;

    // Cold miss and zero-latency re-hit
    #1;
    check("cold_stall", {31'h0, bus.stall_o}, 32'h1);
    cyc();
    check("cold_req", {31'h0, bus.mem_req_o}, 32'h1);
    check("cold_addr", bus.mem_addr_o, 32'h0000_0100);
    bus.mem_done_i = 1'b1; bus.mem_data_i = 32'h0001_0113;
    #1;
    check("cold_fwd_valid", {31'h0, bus.inst_valid_o}, 32'h1);
    check("cold_fwd_inst", bus.inst_o, 32'h0001_0113);
    check("cold_fwd_stall", {31'h0, bus.stall_o}, 32'h0);
    cyc();
    bus.mem_done_i = 1'b0; bus.mem_data_i = 32'h0;
    #1;
    check("rehit_valid", {31'h0, bus.inst_valid_o}, 32'h1);
    check("rehit_inst", bus.inst_o, 32'h0001_0113);
    check("rehit_req", {31'h0, bus.mem_req_o}, 32'h0);

    // Invalidate-all
    bus.inv_all_i = 1'b1;
    #1;
    check("inv_cycle_hit", {31'h0, bus.inst_valid_o}, 32'h1);
    cyc();
    bus.inv_all_i = 1'b0;
    #1;
    check("post_inv_miss", {31'h0, bus.stall_o}, 32'h1);
    fill(32'h0000_0100, 32'h0001_0113);

    // Associativity: 0x100, 0x300, 0x500 share set 64
    fill(32'h0000_0300, 32'h0030_0093);
    fill(32'h0000_0500, 32'h0050_0093);
    bus.pc_i = 32'h0000_0300;
    #1;
    check("assoc_hit_300", {31'h0, bus.inst_valid_o}, 32'h1);
    check("assoc_inst_300", bus.inst_o, 32'h0030_0093);
    bus.pc_i = 32'h0000_0100;
    #1;
    check("assoc_evict_100", {31'h0, bus.stall_o}, 32'h1);
    cyc();
    check("rdy_pre_req", {31'h0, bus.mem_req_o}, 32'h1);

    // rdy low in FILL with an ignored mem_done pulse
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_done_i = (i == 2);
      bus.mem_data_i = (i == 2) ? 32'hBAD0_0001 : 32'h0;
      #1;
      check("rdy_low_req", {31'h0, bus.mem_req_o}, 32'h1);
      check("rdy_low_valid", {31'h0, bus.inst_valid_o}, 32'h0);
      cyc();
    end
    bus.mem_done_i = 1'b0; bus.mem_data_i = 32'h0; rdy = 1'b1;
    #1;
    check("rdy_back_stall", {31'h0, bus.stall_o}, 32'h1);
    cyc();
    bus.mem_done_i = 1'b1; bus.mem_data_i = 32'h0010_0113;
    #1;
    check("rdy_fill_fwd", bus.inst_o, 32'h0010_0113);
    cyc();
    bus.mem_done_i = 1'b0; bus.mem_data_i = 32'h0;
    #1;
    check("rdy_fill_hit", bus.inst_o, 32'h0010_0113);

    // Flush mid-fill: drained response is neither forwarded nor written
    bus.pc_i = 32'h0000_0200;
    cyc();
    check("flush_req_addr", bus.mem_addr_o, 32'h0000_0200);
    cyc();
    bus.flush_i = 1'b1; bus.pc_i = 32'h0000_0400;
    #1;
    check("flush_suppress", {31'h0, bus.stall_o}, 32'h0);
    cyc();
    bus.flush_i = 1'b0;
    #1;
    check("drain_stall", {31'h0, bus.stall_o}, 32'h1);
    check("drain_req", {31'h0, bus.mem_req_o}, 32'h1);
    bus.mem_done_i = 1'b1; bus.mem_data_i = 32'hDEAD_BEEF;
    #1;
    check("drain_nofwd", {31'h0, bus.inst_valid_o}, 32'h0);
    cyc();
    bus.mem_done_i = 1'b0; bus.mem_data_i = 32'h0;
    #1;
    check("post_drain_req", {31'h0, bus.mem_req_o}, 32'h0);
    check("post_drain_miss", {31'h0, bus.stall_o}, 32'h1);
    fill(32'h0000_0400, 32'h0040_0113);
    bus.pc_i = 32'h0000_0200;
    #1;
    check("drain_not_written", {31'h0, bus.stall_o}, 32'h1);
    cyc();

    // Flush in the same cycle as mem_done: written, not forwarded
    bus.flush_i = 1'b1; bus.mem_done_i = 1'b1; bus.mem_data_i = 32'h0020_0113;
    #1;
    check("flush_done_nofwd", {31'h0, bus.inst_valid_o}, 32'h0);
    cyc();
    bus.flush_i = 1'b0; bus.mem_done_i = 1'b0; bus.mem_data_i = 32'h0;
    #1;
    check("flush_done_written", bus.inst_o, 32'h0020_0113);

    // Invalidate in the same cycle as the fill write: forwarded, left invalid
    bus.pc_i = 32'h0000_0600;
    cyc();
    check("inv_fill_addr", bus.mem_addr_o, 32'h0000_0600);
    bus.mem_done_i = 1'b1; bus.inv_all_i = 1'b1; bus.mem_data_i = 32'h0060_0113;
    #1;
    check("inv_fill_fwd", bus.inst_o, 32'h0060_0113);
    cyc();
    bus.mem_done_i = 1'b0; bus.inv_all_i = 1'b0; bus.mem_data_i = 32'h0;
    #1;
    check("inv_fill_invalid", {31'h0, bus.stall_o}, 32'h1);
    bus.pc_i = 32'h0000_0200;
    #1;
    check("inv_clears_200", {31'h0, bus.stall_o}, 32'h1);
    cyc();

    // Asynchronous reset in FILL, off the clock edge
    check("arst_pre_req", {31'h0, bus.mem_req_o}, 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", {31'h0, bus.mem_req_o}, 32'h0);
    check("arst_addr", bus.mem_addr_o, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("arst_miss_200", {31'h0, bus.stall_o}, 32'h1);
    bus.pc_i = 32'h0000_0100;
    #1;
    check("arst_miss_100", {31'h0, bus.stall_o}, 32'h1);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
